// File: rtl/grid_io_multi.sv
// grid_io_multi: multi-channel periphery I/O tile.
// Per-channel OE/IE/input-polarity/output-polarity controls are loaded
// through a counted shift chain (ccff_head -> ccff_tail) and only reach the
// pads once a whole frame has been shifted and committed.
// Optional build macro: GRID_IO_CFG_PARITY_EN adds a leading even-parity bit
// to each frame and refuses to commit frames that fail the parity check.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no frame in progress, cnt = 0
// S_SHIFT  | frame partially shifted, cnt = shifts so far, pause allowed
// S_COMMIT | full frame in sr; copy to act on this edge (may also shift)
module grid_io_multi #(
    parameter int NUM_IO = 4,
    parameter int CFG_W  = 4
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              ccff_en,
    input  logic              ccff_head,
    output logic              ccff_tail,
    output logic              cfg_done,
    output logic              cfg_err,
    input  logic [NUM_IO-1:0] io_outpad,
    output logic [NUM_IO-1:0] io_inpad,
    output logic [NUM_IO-1:0] gfpga_pad_GPIO_A,
    output logic [NUM_IO-1:0] gfpga_pad_GPIO_IE,
    output logic [NUM_IO-1:0] gfpga_pad_GPIO_OE,
    inout  wire  [NUM_IO-1:0] gfpga_pad_GPIO_Y
);

    localparam int L = CFG_W * NUM_IO;
`ifdef GRID_IO_CFG_PARITY_EN
    localparam int CH_LEN = L + 1;
`else
    localparam int CH_LEN = L;
`endif
    localparam int CNT_W = $clog2(L + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CH_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [CH_LEN-1:0] sr;
    logic [L-1:0]      act;
    logic              do_shift;
    logic              do_commit;
    logic              frame_ok;

    assign ccff_tail = sr[CH_LEN-1];

`ifdef GRID_IO_CFG_PARITY_EN
    // Even parity over the whole frame, parity bit included.
    assign frame_ok = ~(^sr);
`else
    assign frame_ok = 1'b1;
`endif

    // State and frame counter registers.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state, counter and shift/commit strobes.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        do_shift   = 1'b0;
        do_commit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (ccff_en) begin
                    do_shift   = 1'b1;
                    cnt_next   = CNT_ONE;
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (ccff_en) begin
                    do_shift = 1'b1;
                    cnt_next = cnt + 1'b1;
                    if (cnt_next == CNT_LAST) begin
                        state_next = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                // A shift on the commit edge starts the next frame without
                // dropping its first bit.
                do_commit  = 1'b1;
                cnt_next   = '0;
                state_next = S_IDLE;
                if (ccff_en) begin
                    do_shift   = 1'b1;
                    cnt_next   = CNT_ONE;
                    state_next = S_SHIFT;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Configuration shift chain; first bit shifted ends at the MSB.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            sr <= '0;
        end else if (do_shift) begin
            sr <= {sr[CH_LEN-2:0], ccff_head};
        end
    end

    // Active configuration; takes sr as it stood before the commit edge.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            act      <= '0;
            cfg_done <= 1'b0;
        end else if (do_commit && frame_ok) begin
            act      <= sr[L-1:0];
            cfg_done <= 1'b1;
        end
    end

`ifdef GRID_IO_CFG_PARITY_EN
    // Parity status of the most recently completed frame.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            cfg_err <= 1'b0;
        end else if (do_commit) begin
            cfg_err <= ~frame_ok;
        end
    end
`else
    assign cfg_err = 1'b0;
`endif

    // Pad control and data paths, combinational from act and the pads.
    always_comb begin
        gfpga_pad_GPIO_OE = '0;
        gfpga_pad_GPIO_IE = '0;
        gfpga_pad_GPIO_A  = '0;
        io_inpad          = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            gfpga_pad_GPIO_OE[i] = act[CFG_W*i];
            gfpga_pad_GPIO_IE[i] = act[CFG_W*i+1];
            gfpga_pad_GPIO_A[i]  = io_outpad[i] ^ act[CFG_W*i+3];
            io_inpad[i]          = act[CFG_W*i+1] &
                                   (gfpga_pad_GPIO_Y[i] ^ act[CFG_W*i+2]);
        end
    end

endmodule

// File: tb/tb_grid_io_multi.sv
// tb_grid_io_multi: directed bench for grid_io_multi (NUM_IO=2, no parity).
// Frames are pushed onto a scoreboard when shifted and popped when the bench
// expects them to commit; pad outputs are checked against that model.
`timescale 1ns/1ps
module tb_grid_io_multi;

    localparam int NUM_IO = 2;
    localparam int L      = 4 * NUM_IO;

    logic              prog_clk = 1'b0;
    logic              prog_rst_n;
    logic              ccff_en;
    logic              ccff_head;
    wire               ccff_tail;
    wire               cfg_done;
    wire               cfg_err;
    logic [NUM_IO-1:0] io_outpad;
    wire  [NUM_IO-1:0] io_inpad;
    wire  [NUM_IO-1:0] gpio_a;
    wire  [NUM_IO-1:0] gpio_ie;
    wire  [NUM_IO-1:0] gpio_oe;
    logic [NUM_IO-1:0] y_drv;
    wire  [NUM_IO-1:0] gpio_y;

    assign gpio_y = y_drv;

    grid_io_multi #(.NUM_IO(NUM_IO)) dut (
        .prog_clk          (prog_clk),
        .prog_rst_n        (prog_rst_n),
        .ccff_en           (ccff_en),
        .ccff_head         (ccff_head),
        .ccff_tail         (ccff_tail),
        .cfg_done          (cfg_done),
        .cfg_err           (cfg_err),
        .io_outpad         (io_outpad),
        .io_inpad          (io_inpad),
        .gfpga_pad_GPIO_A  (gpio_a),
        .gfpga_pad_GPIO_IE (gpio_ie),
        .gfpga_pad_GPIO_OE (gpio_oe),
        .gfpga_pad_GPIO_Y  (gpio_y)
    );

    always #50 prog_clk = ~prog_clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    string      cur_step = "init";

    logic [7:0] exp_q[$];
    logic       tail_q[$];
    logic [7:0] m_act;
    logic       m_done;
    logic       m_tail;
    logic       pending;
    int         nshift;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s [%s]: observed %0h expected %0h", tag, cur_step, obs, exp);
        end
    endtask

    task automatic check_pads();
        logic [1:0] e_a;
        logic [1:0] e_in;
        logic [1:0] e_oe;
        logic [1:0] e_ie;
        for (int k = 0; k < 16; k++) begin
            io_outpad = k[1:0];
            y_drv     = k[3:2];
            #1;
            for (int i = 0; i < NUM_IO; i++) begin
                e_a[i]  = io_outpad[i] ^ m_act[4*i+3];
                e_in[i] = m_act[4*i+1] & (y_drv[i] ^ m_act[4*i+2]);
            end
            chk("gpio_a", 32'(gpio_a), 32'(e_a));
            chk("io_inpad", 32'(io_inpad), 32'(e_in));
        end
        for (int i = 0; i < NUM_IO; i++) begin
            e_oe[i] = m_act[4*i];
            e_ie[i] = m_act[4*i+1];
        end
        chk("gpio_oe", 32'(gpio_oe), 32'(e_oe));
        chk("gpio_ie", 32'(gpio_ie), 32'(e_ie));
        chk("cfg_done", 32'(cfg_done), 32'(m_done));
        chk("cfg_err", 32'(cfg_err), 32'(0));
        chk("ccff_tail", 32'(ccff_tail), 32'(m_tail));
    endtask

    task automatic step(input logic en, input logic b);
        ccff_en   = en;
        ccff_head = b;
        @(posedge prog_clk);
        #1;
        if (pending) begin
            pending = 1'b0;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL scoreboard [%s]: observed empty queue expected a frame", cur_step);
            end else begin
                m_act  = exp_q.pop_front();
                m_done = 1'b1;
            end
        end
        if (en) begin
            tail_q.push_back(b);
            m_tail = tail_q.pop_front();
            nshift++;
            if (nshift == L) begin
                nshift  = 0;
                pending = 1'b1;
            end
        end
        check_pads();
    endtask

    task automatic send_bits(input logic [7:0] v, input int n, input int pause_after, input int pause_len);
        for (int i = 0; i < n; i++) begin
            step(1'b1, v[7-i]);
            if (i + 1 == pause_after) begin
                for (int p = 0; p < pause_len; p++) step(1'b0, 1'b0);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] v, input int pause_after, input int pause_len);
        exp_q.push_back(v);
        send_bits(v, 8, pause_after, pause_len);
    endtask

    task automatic do_reset();
        prog_rst_n = 1'b0;
        #2;
        exp_q.delete();
        tail_q.delete();
        for (int i = 0; i < L - 1; i++) tail_q.push_back(1'b0);
        m_act   = '0;
        m_done  = 1'b0;
        m_tail  = 1'b0;
        pending = 1'b0;
        nshift  = 0;
        check_pads();
        prog_rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        ccff_en   = 1'b0;
        ccff_head = 1'b0;
        io_outpad = 2'b11;
        y_drv     = 2'b11;

        cur_step = "reset";
        do_reset();

        cur_step = "frame_32";
        send_frame(8'h32, 0, 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        cur_step = "frame_32_paused";
        send_frame(8'h32, 4, 3);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        cur_step = "back_to_back";
        send_frame(8'h32, 0, 0);
        send_frame(8'hCC, 0, 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        cur_step = "midframe_reset";
        send_frame(8'h32, 0, 0);
        step(1'b0, 1'b0);
        send_bits(8'hCC, 5, 0, 0);
        do_reset();

        cur_step = "fresh_frame";
        send_frame(8'h9B, 2, 1);
        step(1'b0, 1'b0);
        send_frame(8'h5A, 0, 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        cur_step = "end";
        chk("sb_leftover", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
